// File: rtl/ucode_addr_sel_pkg.sv
// Shared microcode-sequencer definitions: address-select FSM states and
// the field_18 jump-type encodings used by the next-address decode.
package ucode_addr_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } useq_state_e;

    // field_18 bits [6:5]: how a_oprd[0] steers the next address
    localparam logic [1:0] F18_JMP_SEQ      = 2'b00;
    localparam logic [1:0] F18_JMP_HANDLE2  = 2'b01;
    localparam logic [1:0] F18_JMP_HANDLE   = 2'b10;
    localparam logic [1:0] F18_JMP_HANDLE_P = 2'b11;

    // {bit1,bit0} codes produced by the jump decode
    localparam logic [1:0] NSEL_PLUS2 = 2'b10;
    localparam logic [1:0] NSEL_PLUS3 = 2'b11;

endpackage

// File: rtl/ucode_jmp_dec.sv
// Next-address decode: chooses address+1/+2/+3 from the field_18 jump
// type and the handle bit a_oprd[0].
module ucode_jmp_dec #(
    parameter int ADDR_W = 9
) (
    input  logic [1:0]        jmp,
    input  logic              a0,
    input  logic [ADDR_W-1:0] nxt_addr_1,
    input  logic [ADDR_W-1:0] nxt_addr_2,
    input  logic [ADDR_W-1:0] nxt_addr_3,
    output logic [ADDR_W-1:0] next_addr
);
    import ucode_addr_sel_pkg::*;

    logic handle2;
    logic handle;
    logic handle_p;
    logic bit1;
    logic bit0;

    assign handle2  = (jmp == F18_JMP_HANDLE2);
    assign handle   = (jmp == F18_JMP_HANDLE);
    assign handle_p = (jmp == F18_JMP_HANDLE_P);

    assign bit1 = (handle & ~a0) | (handle_p & a0) | (handle2 & a0);
    assign bit0 = (handle & ~a0) | (handle_p & a0) | ~(handle2 & a0);

    // 2'b00 cannot occur; it falls into the sequential (+1) case
    always_comb begin
        next_addr = nxt_addr_1;
        case ({bit1, bit0})
            NSEL_PLUS2: next_addr = nxt_addr_2;
            NSEL_PLUS3: next_addr = nxt_addr_3;
            default:    next_addr = nxt_addr_1;
        endcase
    end

endmodule

// File: rtl/ucode_addr_sel.sv
// Microcode ROM address select: takes R-stage entry addresses, steps the
// routine via the jump decode, buffers one overlapping start, counts cycles.
module ucode_addr_sel #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rom_start_r,
    input  logic              u_done,
    input  logic              ie_stall_ucode,
    input  logic              ie_kill_ucode,
    input  logic [1:0]        u_f18_jmp,
    input  logic              a_oprd_0,
    input  logic [ADDR_W-1:0] nxt_addr_1,
    input  logic [ADDR_W-1:0] nxt_addr_2,
    input  logic [ADDR_W-1:0] nxt_addr_3,
    output logic [ADDR_W-1:0] rom_addr_l,
    output logic              ucode_in_r,
    output logic              ucode_hold_r,
    output logic [CNT_W-1:0]  ucode_cyc_cnt
);
    import ucode_addr_sel_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    useq_state_e       state;
    logic [ADDR_W-1:0] rom_addr;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              start_req;

    assign start_req    = |rom_start_r;
    assign rom_addr_l   = ~rom_addr;
    assign ucode_hold_r = (state == ST_HOLD);

    ucode_jmp_dec #(
        .ADDR_W(ADDR_W)
    ) u_jmp_dec (
        .jmp        (u_f18_jmp),
        .a0         (a_oprd_0),
        .nxt_addr_1 (nxt_addr_1),
        .nxt_addr_2 (nxt_addr_2),
        .nxt_addr_3 (nxt_addr_3),
        .next_addr  (next_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            rom_addr      <= '0;
            pend_addr     <= '0;
            ucode_in_r    <= 1'b0;
            ucode_cyc_cnt <= '0;
        end else if (ie_kill_ucode) begin
            // kill wins over stall and any start; the counter keeps its value
            state      <= ST_IDLE;
            rom_addr   <= '0;
            pend_addr  <= '0;
            ucode_in_r <= 1'b0;
        end else if (ie_stall_ucode) begin
            ucode_in_r <= 1'b0;
        end else begin
            ucode_in_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state         <= ST_RUN;
                        rom_addr      <= rom_start_r;
                        ucode_in_r    <= 1'b1;
                        ucode_cyc_cnt <= CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (u_done) begin
                        if (start_req) begin
                            rom_addr      <= rom_start_r;
                            ucode_in_r    <= 1'b1;
                            ucode_cyc_cnt <= CNT_ONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        rom_addr <= next_addr;
                        if (ucode_cyc_cnt != CNT_MAX)
                            ucode_cyc_cnt <= ucode_cyc_cnt + CNT_ONE;
                        // overlapping start: park it until the routine ends
                        if (start_req) begin
                            state     <= ST_HOLD;
                            pend_addr <= rom_start_r;
                        end
                    end
                end
                ST_HOLD: begin
                    if (u_done) begin
                        state         <= ST_RUN;
                        rom_addr      <= pend_addr;
                        ucode_in_r    <= 1'b1;
                        ucode_cyc_cnt <= CNT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
